// File: rtl/lc3_modport_if.sv
// Bus bundle between the LC-3 core and its instruction/data memories.
// The core drives the master side and the memory model drives the slave side.
interface lc3_modport_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_rd;
  logic [15:0] Data_dout;
  logic        complete_data;

  modport master (
    output pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface

// File: rtl/lc3_modport.sv
// Multi-cycle LC-3 core (ADD, AND, NOT, LD, LDR, LDI, LEA, ST, STR, STI, BR, JMP).
// Optional feature: define LC3_INSTR_COUNT_EN to add twelve 32-bit
// retired-instruction counters, readable hierarchically.
module lc3_modport (
  input logic           clock,
  input logic           reset,
  lc3_modport_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM_IND, MEM_ACC, WRITEBACK, UPDATEPC
  } state_e;

  typedef enum logic [3:0] {
    OP_BR  = 4'h0,
    OP_ADD = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_AND = 4'h5,
    OP_LDR = 4'h6,
    OP_STR = 4'h7,
    OP_NOT = 4'h9,
    OP_LDI = 4'hA,
    OP_STI = 4'hB,
    OP_JMP = 4'hC,
    OP_LEA = 4'hE
  } opcode_e;

  state_e      state, next_state;
  opcode_e     op;

  logic [15:0] pc;
  logic [15:0] npc;
  logic [15:0] ir;
  logic [15:0] regs [8];
  logic [2:0]  psr;

  logic [15:0] sr1_val;
  logic [15:0] sr2_val;
  logic [15:0] st_val;
  logic [15:0] alu_out;
  logic [15:0] address;
  logic [15:0] memout;
  logic [15:0] taddr;
  logic        br_taken;

  logic [15:0] imm5;
  logic [15:0] off6;
  logic [15:0] off9;
  logic [15:0] alu_op2;
  logic        is_load;
  logic        is_store;
  logic [15:0] wb_val;

  // Instruction field decode and derived operands
  always_comb begin
    op       = opcode_e'(ir[15:12]);
    imm5     = {{11{ir[4]}}, ir[4:0]};
    off6     = {{10{ir[5]}}, ir[5:0]};
    off9     = {{7{ir[8]}}, ir[8:0]};
    alu_op2  = ir[5] ? imm5 : sr2_val;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      OP_LD, OP_LDR, OP_LDI: is_load  = 1'b1;
      OP_ST, OP_STR, OP_STI: is_store = 1'b1;
      default: ;
    endcase
    if (is_load) begin
      wb_val = memout;
    end else if (op == OP_LEA) begin
      wb_val = address;
    end else begin
      wb_val = alu_out;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; memory states wait for their completion strobe
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (bus.complete_instr) next_state = DECODE;
      end
      DECODE: next_state = EXECUTE;
      EXECUTE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: next_state = WRITEBACK;
          OP_LD, OP_LDR, OP_ST, OP_STR:   next_state = MEM_ACC;
          OP_LDI, OP_STI:                 next_state = MEM_IND;
          default:                        next_state = UPDATEPC;
        endcase
      end
      MEM_IND: begin
        if (bus.complete_data) next_state = MEM_ACC;
      end
      MEM_ACC: begin
        if (bus.complete_data) next_state = is_load ? WRITEBACK : UPDATEPC;
      end
      WRITEBACK: next_state = UPDATEPC;
      UPDATEPC:  next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  // Datapath registers, register file and condition codes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= 16'h3000;
      npc      <= '0;
      ir       <= '0;
      psr      <= 3'b010;
      sr1_val  <= '0;
      sr2_val  <= '0;
      st_val   <= '0;
      alu_out  <= '0;
      address  <= '0;
      memout   <= '0;
      taddr    <= '0;
      br_taken <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (bus.complete_instr) begin
            ir  <= bus.Instr_dout;
            npc <= pc + 16'd1;
          end
        end
        DECODE: begin
          sr1_val <= regs[ir[8:6]];
          sr2_val <= regs[ir[2:0]];
          st_val  <= regs[ir[11:9]];
        end
        EXECUTE: begin
          case (op)
            OP_ADD: alu_out <= sr1_val + alu_op2;
            OP_AND: alu_out <= sr1_val & alu_op2;
            OP_NOT: alu_out <= ~sr1_val;
            OP_LEA, OP_LD, OP_ST, OP_LDI, OP_STI: address <= npc + off9;
            OP_LDR, OP_STR: address <= sr1_val + off6;
            OP_BR: begin
              taddr    <= npc + off9;
              br_taken <= |(ir[11:9] & psr);
            end
            OP_JMP: begin
              taddr    <= sr1_val;
              br_taken <= 1'b1;
            end
            default: ;
          endcase
        end
        MEM_IND: begin
          if (bus.complete_data) address <= bus.Data_dout;
        end
        MEM_ACC: begin
          if (bus.complete_data && is_load) memout <= bus.Data_dout;
        end
        WRITEBACK: begin
          regs[ir[11:9]] <= wb_val;
          psr <= {wb_val[15], wb_val == '0, !wb_val[15] && (wb_val != '0)};
        end
        UPDATEPC: begin
          pc       <= br_taken ? taddr : npc;
          br_taken <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs, decoded from registered state only.
  // The fetch request is additionally gated by reset so it reads low while
  // the core is held in reset even though the state register already sits in FETCH.
  always_comb begin
    bus.pc          = pc;
    bus.instrmem_rd = reset && (state == FETCH);
    bus.Data_addr   = '0;
    bus.Data_din    = '0;
    bus.Data_rd     = 1'b1;
    if (state == MEM_IND || state == MEM_ACC) begin
      bus.Data_addr = address;
    end
    if (state == MEM_ACC && is_store) begin
      bus.Data_rd  = 1'b0;
      bus.Data_din = st_val;
    end
  end

`ifdef LC3_INSTR_COUNT_EN
  logic [31:0] addc, andc, notc, ldc, ldrc, ldic, leac, stc, strc, stic, jmpc, brc;

  // Retired-instruction counters, bumped once as each instruction leaves UPDATEPC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addc <= '0;
      andc <= '0;
      notc <= '0;
      ldc  <= '0;
      ldrc <= '0;
      ldic <= '0;
      leac <= '0;
      stc  <= '0;
      strc <= '0;
      stic <= '0;
      jmpc <= '0;
      brc  <= '0;
    end else if (state == UPDATEPC) begin
      case (op)
        OP_ADD: addc <= addc + 32'd1;
        OP_AND: andc <= andc + 32'd1;
        OP_NOT: notc <= notc + 32'd1;
        OP_LD:  ldc  <= ldc  + 32'd1;
        OP_LDR: ldrc <= ldrc + 32'd1;
        OP_LDI: ldic <= ldic + 32'd1;
        OP_LEA: leac <= leac + 32'd1;
        OP_ST:  stc  <= stc  + 32'd1;
        OP_STR: strc <= strc + 32'd1;
        OP_STI: stic <= stic + 32'd1;
        OP_JMP: jmpc <= jmpc + 32'd1;
        OP_BR:  brc  <= brc  + 32'd1;
        default: ;
      endcase
    end
  end
`else
  // Counters compiled out; functional behaviour is unchanged.
`endif

endmodule

// File: tb/tb_lc3_modport.sv
// Self-checking bench for lc3_modport: directed scenarios plus a randomized
// program run checked against an instruction-level LC-3 model.
module tb_lc3_modport;

  logic clock = 1'b0;
  logic reset = 1'b0;

  lc3_modport_if bus ();

  lc3_modport dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem     [65536];
  logic [15:0] mem_ref [65536];
  logic [15:0] rf_ref  [8];
  logic [2:0]  psr_ref;
  logic [15:0] pc_ref;
  logic [31:0] exp_st_q [$];
  logic [31:0] act_st_q [$];

  int mode;   // 0: zero-wait, 1: random waits, 2: data memory stalled
  int n_vec;
  int n_err;

  // Memory responder: drives read data and completion away from the active edge
  task automatic mem_driver();
    forever begin
      @(negedge clock);
      bus.Instr_dout = mem[bus.pc];
      bus.Data_dout  = mem[bus.Data_addr];
      case (mode)
        0: begin
          bus.complete_instr = 1'b1;
          bus.complete_data  = 1'b1;
        end
        1: begin
          bus.complete_instr = ($urandom_range(0, 2) != 0);
          bus.complete_data  = ($urandom_range(0, 2) != 0);
        end
        default: begin
          bus.complete_instr = 1'b1;
          bus.complete_data  = 1'b0;
        end
      endcase
    end
  endtask

  // Memory write port: a store is accepted when Data_rd=0 meets complete_data at an edge
  task automatic mem_monitor();
    forever begin
      @(posedge clock);
      if (reset && !bus.Data_rd && bus.complete_data) begin
        mem[bus.Data_addr] = bus.Data_din;
        act_st_q.push_back({bus.Data_addr, bus.Data_din});
      end
    end
  endtask

  task automatic fill_mem(input bit rnd);
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = rnd ? 16'($urandom) : 16'h0000;
      mem[i]     = w;
      mem_ref[i] = w;
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    act_st_q.delete();
    exp_st_q.delete();
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Instruction-level LC-3 model: one call executes one whole instruction
  task automatic ref_step();
    logic [15:0] ins, npc, newpc, val, ea, off9, off6, op2;
    logic        wr;
    ins   = mem_ref[pc_ref];
    npc   = pc_ref + 16'd1;
    newpc = npc;
    wr    = 1'b0;
    val   = 16'h0000;
    off9  = {{7{ins[8]}}, ins[8:0]};
    off6  = {{10{ins[5]}}, ins[5:0]};
    op2   = ins[5] ? {{11{ins[4]}}, ins[4:0]} : rf_ref[ins[2:0]];
    case (ins[15:12])
      4'h1: begin val = rf_ref[ins[8:6]] + op2; wr = 1'b1; end
      4'h5: begin val = rf_ref[ins[8:6]] & op2; wr = 1'b1; end
      4'h9: begin val = ~rf_ref[ins[8:6]];      wr = 1'b1; end
      4'hE: begin val = npc + off9;             wr = 1'b1; end
      4'h2: begin ea = npc + off9; val = mem_ref[ea]; wr = 1'b1; end
      4'h6: begin ea = rf_ref[ins[8:6]] + off6; val = mem_ref[ea]; wr = 1'b1; end
      4'hA: begin ea = npc + off9; ea = mem_ref[ea]; val = mem_ref[ea]; wr = 1'b1; end
      4'h3, 4'h7, 4'hB: begin
        if (ins[15:12] == 4'h7) ea = rf_ref[ins[8:6]] + off6;
        else ea = npc + off9;
        if (ins[15:12] == 4'hB) ea = mem_ref[ea];
        mem_ref[ea] = rf_ref[ins[11:9]];
        exp_st_q.push_back({ea, rf_ref[ins[11:9]]});
      end
      4'h0: if ((ins[11:9] & psr_ref) != 3'b000) newpc = npc + off9;
      4'hC: newpc = rf_ref[ins[8:6]];
      default: ;
    endcase
    if (wr) begin
      rf_ref[ins[11:9]] = val;
      psr_ref = val[15] ? 3'b100 : ((val == 16'h0000) ? 3'b010 : 3'b001);
    end
    pc_ref = newpc;
  endtask

  task automatic test_reset();
    mode = 0;
    fill_mem(1'b0);
    hold_reset();
    n_vec++; if (bus.pc !== 16'h3000) begin n_err++; $display("FAIL reset_pc: got %h expected 3000", bus.pc); end
    n_vec++; if (bus.instrmem_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd_low: got %b expected 0", bus.instrmem_rd); end
    n_vec++; if (bus.Data_rd !== 1'b1) begin n_err++; $display("FAIL reset_data_rd: got %b expected 1", bus.Data_rd); end
    n_vec++; if (bus.Data_addr !== 16'h0000) begin n_err++; $display("FAIL reset_data_addr: got %h expected 0000", bus.Data_addr); end
    n_vec++; if (bus.Data_din !== 16'h0000) begin n_err++; $display("FAIL reset_data_din: got %h expected 0000", bus.Data_din); end
    release_reset();
    #1;
    n_vec++; if (bus.instrmem_rd !== 1'b1) begin n_err++; $display("FAIL first_fetch_rd: got %b expected 1", bus.instrmem_rd); end
    n_vec++; if (bus.pc !== 16'h3000) begin n_err++; $display("FAIL first_fetch_pc: got %h expected 3000", bus.pc); end
    n_vec++; if (dut.psr !== 3'b010) begin n_err++; $display("FAIL reset_psr: got %b expected 010", dut.psr); end
    for (int r = 0; r < 8; r++) begin
      n_vec++; if (dut.regs[r] !== 16'h0000) begin n_err++; $display("FAIL reset_r%0d: got %h expected 0000", r, dut.regs[r]); end
    end
  endtask

  task automatic test_and_add();
    mode = 0;
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h5260;
    mem[16'h3001] = 16'h127D;
    release_reset();
    repeat (10) @(posedge clock);
    @(negedge clock);
    n_vec++; if (dut.regs[1] !== 16'hFFFD) begin n_err++; $display("FAIL add_r1: got %h expected fffd", dut.regs[1]); end
    n_vec++; if (dut.psr !== 3'b100) begin n_err++; $display("FAIL add_psr: got %b expected 100", dut.psr); end
    n_vec++; if (bus.pc !== 16'h3002) begin n_err++; $display("FAIL add_pc: got %h expected 3002", bus.pc); end
  endtask

  task automatic test_ld();
    mode = 0;
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h2202;
    mem[16'h3003] = 16'h1234;
    release_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.Data_addr !== 16'h3003) begin n_err++; $display("FAIL ld_addr: got %h expected 3003", bus.Data_addr); end
    n_vec++; if (bus.Data_rd !== 1'b1) begin n_err++; $display("FAIL ld_rd: got %b expected 1", bus.Data_rd); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (dut.regs[1] !== 16'h1234) begin n_err++; $display("FAIL ld_r1: got %h expected 1234", dut.regs[1]); end
    n_vec++; if (dut.psr !== 3'b001) begin n_err++; $display("FAIL ld_psr: got %b expected 001", dut.psr); end
    n_vec++; if (bus.pc !== 16'h3001) begin n_err++; $display("FAIL ld_pc: got %h expected 3001", bus.pc); end
  endtask

  task automatic test_sti();
    mode = 0;
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h2403;   // LD  R2,#3  -> R2 = mem[x3004]
    mem[16'h3001] = 16'hB400;   // STI R2,#0  -> pointer at x3002
    mem[16'h3002] = 16'h4000;
    mem[16'h3004] = 16'h00AA;
    release_reset();
    repeat (9) @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.Data_addr !== 16'h3002) begin n_err++; $display("FAIL sti_ind_addr: got %h expected 3002", bus.Data_addr); end
    n_vec++; if (bus.Data_rd !== 1'b1) begin n_err++; $display("FAIL sti_ind_rd: got %b expected 1", bus.Data_rd); end
    @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.Data_addr !== 16'h4000) begin n_err++; $display("FAIL sti_wr_addr: got %h expected 4000", bus.Data_addr); end
    n_vec++; if (bus.Data_din !== 16'h00AA) begin n_err++; $display("FAIL sti_wr_din: got %h expected 00aa", bus.Data_din); end
    n_vec++; if (bus.Data_rd !== 1'b0) begin n_err++; $display("FAIL sti_wr_rd: got %b expected 0", bus.Data_rd); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++; if (act_st_q.size() !== 1) begin n_err++; $display("FAIL sti_store_count: got %0d expected 1", act_st_q.size()); end
    n_vec++; if (mem[16'h4000] !== 16'h00AA) begin n_err++; $display("FAIL sti_mem: got %h expected 00aa", mem[16'h4000]); end
    n_vec++; if (bus.pc !== 16'h3002) begin n_err++; $display("FAIL sti_pc: got %h expected 3002", bus.pc); end
  endtask

  task automatic test_branch();
    mode = 0;
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h0404;   // BRz #4 with psr=010 -> taken
    release_reset();
    repeat (4) @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.pc !== 16'h3005) begin n_err++; $display("FAIL brz_taken_pc: got %h expected 3005", bus.pc); end
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h1261;   // ADD R1,R1,#1 -> psr=001
    mem[16'h3001] = 16'h0404;   // BRz #4 -> not taken
    release_reset();
    repeat (9) @(posedge clock);
    @(negedge clock);
    n_vec++; if (dut.psr !== 3'b001) begin n_err++; $display("FAIL brz_psr: got %b expected 001", dut.psr); end
    n_vec++; if (bus.pc !== 16'h3002) begin n_err++; $display("FAIL brz_not_taken_pc: got %h expected 3002", bus.pc); end
  endtask

  task automatic test_wait_abort();
    mode = 2;
    fill_mem(1'b0);
    hold_reset();
    mem[16'h3000] = 16'h2202;
    mem[16'h3003] = 16'h5555;
    release_reset();
    repeat (3) @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++; if (bus.Data_addr !== 16'h3003) begin n_err++; $display("FAIL wait_addr[%0d]: got %h expected 3003", k, bus.Data_addr); end
      n_vec++; if (bus.Data_rd !== 1'b1) begin n_err++; $display("FAIL wait_rd[%0d]: got %b expected 1", k, bus.Data_rd); end
      n_vec++; if (bus.instrmem_rd !== 1'b0) begin n_err++; $display("FAIL wait_fetch[%0d]: got %b expected 0", k, bus.instrmem_rd); end
      if (k < 3) @(posedge clock);
    end
    reset = 1'b0;
    #1;
    n_vec++; if (bus.pc !== 16'h3000) begin n_err++; $display("FAIL abort_pc: got %h expected 3000", bus.pc); end
    n_vec++; if (dut.regs[1] !== 16'h0000) begin n_err++; $display("FAIL abort_r1: got %h expected 0000", dut.regs[1]); end
    n_vec++; if (bus.Data_addr !== 16'h0000) begin n_err++; $display("FAIL abort_addr: got %h expected 0000", bus.Data_addr); end
    mode = 0;
    @(negedge clock);
    release_reset();
    #1;
    n_vec++; if (dut.regs[1] !== 16'h0000) begin n_err++; $display("FAIL abort_r1_after: got %h expected 0000", dut.regs[1]); end
    repeat (6) @(posedge clock);
    @(negedge clock);
    n_vec++; if (dut.regs[1] !== 16'h5555) begin n_err++; $display("FAIL restart_r1: got %h expected 5555", dut.regs[1]); end
    n_vec++; if (bus.pc !== 16'h3001) begin n_err++; $display("FAIL restart_pc: got %h expected 3001", bus.pc); end
  endtask

  task automatic test_random();
    logic [3:0]  ops [12];
    logic [15:0] w;
    logic [31:0] e, a;
    bit          prev, got;
    ops = '{4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'hE, 4'h3, 4'h7, 4'hB, 4'h0, 4'hC};
    mode = 1;
    fill_mem(1'b1);
    hold_reset();
    for (int adr = 16'h3000; adr < 16'h3100; adr++) begin
      w = {ops[$urandom_range(0, 11)], 12'($urandom)};
      mem[adr]     = w;
      mem_ref[adr] = w;
    end
    for (int r = 0; r < 8; r++) rf_ref[r] = 16'h0000;
    psr_ref = 3'b010;
    pc_ref  = 16'h3000;
    release_reset();
    prev = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ref_step();
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(negedge clock);
        if (bus.instrmem_rd && !prev) got = 1'b1;
        prev = bus.instrmem_rd;
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL rnd_timeout[%0d]: got no retirement expected one within 400 cycles", n);
        break;
      end
      n_vec++; if (bus.pc !== pc_ref) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, bus.pc, pc_ref); end
      n_vec++; if (dut.psr !== psr_ref) begin n_err++; $display("FAIL rnd_psr[%0d]: got %b expected %b", n, dut.psr, psr_ref); end
      for (int r = 0; r < 8; r++) begin
        n_vec++; if (dut.regs[r] !== rf_ref[r]) begin n_err++; $display("FAIL rnd_r%0d[%0d]: got %h expected %h", r, n, dut.regs[r], rf_ref[r]); end
      end
      while (exp_st_q.size() > 0) begin
        e = exp_st_q.pop_front();
        a = (act_st_q.size() > 0) ? act_st_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (a !== e) begin n_err++; $display("FAIL rnd_store[%0d]: got addr/data %h expected %h", n, a, e); end
      end
      n_vec++; if (act_st_q.size() !== 0) begin n_err++; $display("FAIL rnd_extra_store[%0d]: got %0d extra expected 0", n, act_st_q.size()); act_st_q.delete(); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mode  = 0;
    bus.Instr_dout     = 16'h0000;
    bus.Data_dout      = 16'h0000;
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    fork
      mem_driver();
      mem_monitor();
    join_none
    test_reset();
    test_and_add();
    test_ld();
    test_sti();
    test_branch();
    test_wait_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
